// File: rtl/asym_ram_pkg.sv
// Shared state encoding and sizing helpers for the asymmetric RAM write-side packer.
package asym_ram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      FLUSH
   } state_t;

   localparam int DEF_WIDTHB = 8;
   localparam int DEF_WIDTHA = 16;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   function automatic int lane_ratio(input int width_a, input int width_b);
      return width_a / width_b;
   endfunction

   localparam int DEF_RATIO = lane_ratio(DEF_WIDTHA, DEF_WIDTHB);

endpackage

// File: rtl/asym_ram_lane_acc.sv
// Byte-lane accumulator: collects bytes by lane index and presents the word that
// would be written now, with every lane not yet filled replaced by PAD.
module asym_ram_lane_acc
   import asym_ram_pkg::*;
#(
   parameter int                WIDTHB = DEF_WIDTHB,
   parameter int                RATIO  = DEF_RATIO,
   parameter int                LANEW  = 1,
   parameter logic [WIDTHB-1:0] PAD    = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [LANEW-1:0]        lane,
   input  logic [WIDTHB-1:0]       data,
   output logic [RATIO*WIDTHB-1:0] word
);

   logic [WIDTHB-1:0] lanes [RATIO];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < RATIO; k++) begin
            lanes[k] <= '0;
         end
      end else if (load) begin
         lanes[lane] <= data;
      end
   end

   // Lanes above the current index may hold stale bytes from an older word, so they are masked.
   always_comb begin
      word = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (k < int'(lane)) begin
            word[k*WIDTHB +: WIDTHB] = lanes[k];
         end else if (k == int'(lane) && load) begin
            word[k*WIDTHB +: WIDTHB] = data;
         end else begin
            word[k*WIDTHB +: WIDTHB] = PAD;
         end
      end
   end

endmodule

// File: rtl/asym_ram_wr_packer.sv
// Packs a byte stream into WIDTHA-wide words and drives the write port of the
// asymmetric RAM with an auto-incrementing, wrapping address.
module asym_ram_wr_packer
   import asym_ram_pkg::*;
#(
   parameter int                WIDTHB     = DEF_WIDTHB,
   parameter int                WIDTHA     = DEF_WIDTHA,
   parameter int                RATIO      = lane_ratio(WIDTHA, WIDTHB),
   parameter int                ADDRWIDTHA = 8,
   parameter int                SIZEA      = 256,
   parameter logic [WIDTHB-1:0] PAD        = '0
) (
   input  logic                  clkA,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDRWIDTHA-1:0] base_addr,
   input  logic                  flush,
   input  logic                  stop,
   input  logic                  in_valid,
   input  logic [WIDTHB-1:0]     in_data,
   output logic                  in_ready,
   output logic                  enaA,
   output logic                  weA,
   output logic [ADDRWIDTHA-1:0] addrA,
   output logic [WIDTHA-1:0]     diA,
   output logic [ADDRWIDTHA:0]   word_cnt,
   output logic                  wrap,
   output logic                  busy
);

   localparam int                    LANEW     = (clog2(RATIO) > 0) ? clog2(RATIO) : 1;
   localparam logic [LANEW-1:0]      LAST_LANE = LANEW'(RATIO - 1);
   localparam logic [ADDRWIDTHA-1:0] LAST_ADDR = ADDRWIDTHA'(SIZEA - 1);

   if (!((RATIO == 2 || RATIO == 4) && WIDTHA == RATIO * WIDTHB)) begin : g_bad_config
      $error("asym_ram_wr_packer: WIDTHA must be exactly 2 or 4 times WIDTHB");
   end

   state_t                  state;
   state_t                  next_state;
   logic [LANEW-1:0]        lane;
   logic [ADDRWIDTHA-1:0]   ptr;
   logic                    stop_pending;
   logic                    wrap_pending;
   logic                    accept;
   logic                    completes;
   logic                    do_flush;
   logic                    pad_write;
   logic                    write_now;
   logic [WIDTHA-1:0]       word;

   assign accept    = in_valid && in_ready;
   assign completes = accept && (lane == LAST_LANE);
   assign do_flush  = (state == ACTIVE) && (flush || stop);
   assign pad_write = do_flush && !completes && (accept || (lane != '0));
   assign write_now = completes || pad_write;

   asym_ram_lane_acc #(
      .WIDTHB (WIDTHB),
      .RATIO  (RATIO),
      .LANEW  (LANEW),
      .PAD    (PAD)
   ) u_lane_acc (
      .clk  (clkA),
      .rst  (rst),
      .load (accept),
      .lane (lane),
      .data (in_data),
      .word (word)
   );

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = ACTIVE;
         ACTIVE:  if (flush || stop) next_state = FLUSH;
         FLUSH:   next_state = stop_pending ? IDLE : ACTIVE;
         default: next_state = IDLE;
      endcase
   end

   // wrap is raised on the first write after the pointer rolled over, i.e. the write at address 0.
   always_ff @(posedge clkA) begin
      if (rst) begin
         state        <= IDLE;
         lane         <= '0;
         ptr          <= '0;
         stop_pending <= 1'b0;
         wrap_pending <= 1'b0;
         in_ready     <= 1'b0;
         busy         <= 1'b0;
         enaA         <= 1'b0;
         weA          <= 1'b0;
         addrA        <= '0;
         diA          <= '0;
         word_cnt     <= '0;
         wrap         <= 1'b0;
      end else begin
         state    <= next_state;
         in_ready <= (next_state == ACTIVE);
         busy     <= (next_state != IDLE);
         enaA     <= write_now;
         weA      <= write_now;
         wrap     <= write_now && wrap_pending;

         if (state == IDLE && start) begin
            ptr          <= base_addr;
            word_cnt     <= '0;
            wrap_pending <= 1'b0;
         end

         if (do_flush) begin
            stop_pending <= stop;
         end

         if (write_now) begin
            addrA        <= ptr;
            diA          <= word;
            wrap_pending <= (ptr == LAST_ADDR);
            ptr          <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
            if (word_cnt != '1) begin
               word_cnt <= word_cnt + 1'b1;
            end
         end

         if (state == IDLE || do_flush || completes) begin
            lane <= '0;
         end else if (accept) begin
            lane <= lane + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_asym_ram_wr_packer.sv
// Self-checking bench for asym_ram_wr_packer: directed scenarios plus a long randomized
// run compared against a queue-based model of the packing rules and a RAM image.
module tb_asym_ram_wr_packer;

   localparam int RATIO = 2;
   localparam int SIZEA = 256;
   localparam int M_IDLE = 0;
   localparam int M_ACTIVE = 1;
   localparam int M_FLUSH = 2;

   logic        clkA = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic        stop = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  base_addr = '0;
   logic [7:0]  in_data = '0;
   logic        in_ready;
   logic        enaA;
   logic        weA;
   logic [7:0]  addrA;
   logic [15:0] diA;
   logic [8:0]  word_cnt;
   logic        wrap;
   logic        busy;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
      logic        wrap;
      logic        ok;
      int          cyc;
   } wr_t;

   wr_t obs_q[$];
   wr_t exp_q[$];

   int         m_mode = M_IDLE;
   int         m_ptr = 0;
   int         m_cnt = 0;
   bit         m_stop = 1'b0;
   bit         m_wrap_pend = 1'b0;
   logic [7:0] m_bytes[$];
   logic       last_rdy;
   int         last_cyc;

   logic [15:0] mem_dut [SIZEA];
   logic [15:0] mem_ref [SIZEA];

   asym_ram_wr_packer dut (
      .clkA      (clkA),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .flush     (flush),
      .stop      (stop),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .enaA      (enaA),
      .weA       (weA),
      .addrA     (addrA),
      .diA       (diA),
      .word_cnt  (word_cnt),
      .wrap      (wrap),
      .busy      (busy)
   );

   always #5 clkA = ~clkA;

   always @(posedge clkA) cyc <= cyc + 1;

   // Every cycle showing write activity or a wrap pulse is logged for the scenario checks.
   always @(negedge clkA) begin
      if (enaA === 1'b1 || weA === 1'b1 || wrap === 1'b1) begin
         obs_q.push_back('{addrA, diA, wrap, enaA && weA, cyc});
      end
   end

   // One clock of stimulus; the model decides acceptance and expected writes from the rules alone.
   task automatic step(input logic v, input logic [7:0] d, input logic fl, input logic st,
                       input logic sa, input logic [7:0] base);
      logic [15:0] w;
      @(negedge clkA);
      in_valid  = v;
      in_data   = d;
      flush     = fl;
      stop      = st;
      start     = sa;
      base_addr = base;
      last_rdy  = in_ready;
      last_cyc  = cyc;
      case (m_mode)
         M_ACTIVE: begin
            if (v) m_bytes.push_back(d);
            if (m_bytes.size() == RATIO || ((fl || st) && m_bytes.size() != 0)) begin
               w = '0;
               foreach (m_bytes[k]) w[k*8 +: 8] = m_bytes[k];
               exp_q.push_back('{8'(m_ptr), w, m_wrap_pend, 1'b1, cyc + 1});
               m_wrap_pend = (m_ptr == SIZEA - 1);
               m_ptr = (m_ptr + 1) % SIZEA;
               if (m_cnt < 511) m_cnt++;
               m_bytes.delete();
            end
            if (fl || st) begin
               m_mode = M_FLUSH;
               m_stop = st;
            end
         end
         M_FLUSH: m_mode = m_stop ? M_IDLE : M_ACTIVE;
         default: begin
            if (sa) begin
               m_mode = M_ACTIVE;
               m_ptr = int'(base);
               m_cnt = 0;
               m_wrap_pend = 1'b0;
               m_bytes.delete();
            end
         end
      endcase
      @(posedge clkA);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic begin_session(input logic [7:0] base);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      idle(1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, base);
   endtask

   task automatic do_reset();
      @(negedge clkA);
      rst      = 1'b1;
      in_valid = 1'b0;
      flush    = 1'b0;
      stop     = 1'b0;
      start    = 1'b0;
      @(posedge clkA);
      #1;
      rst = 1'b0;
      m_mode = M_IDLE;
      m_ptr = 0;
      m_cnt = 0;
      m_wrap_pend = 1'b0;
      m_bytes.delete();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({enaA, weA, addrA, diA, word_cnt, wrap, busy, in_ready} !== 38'h0)
         $display("[TB] FAIL reset_outputs: got %h want 0",
                  {enaA, weA, addrA, diA, word_cnt, wrap, busy, in_ready});
      else n_pass++;
      obs_q.delete();
      idle(2);
      n_checks++;
      if (last_rdy !== 1'b0 || obs_q.size() != 0)
         $display("[TB] FAIL reset_idle: got ready=%b writes=%0d want ready=0 writes=0",
                  last_rdy, obs_q.size());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [7:0]  ea [2] = '{8'h10, 8'h11};
      logic [15:0] ed [2] = '{16'h2211, 16'h4433};
      logic [7:0]  bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      int          wcyc [2];
      obs_q.delete();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10);
      for (int i = 0; i < 4; i++) begin
         send(bytes[i]);
         if (i % 2 == 1) wcyc[i/2] = last_cyc + 1;
         n_checks++;
         if (last_rdy !== 1'b1) $display("[TB] FAIL b2b_ready%0d: got %b want 1", i, last_rdy);
         else n_pass++;
      end
      idle(2);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (i >= obs_q.size())
            $display("[TB] FAIL b2b_write%0d: got none want %h @%h", i, ed[i], ea[i]);
         else if (obs_q[i].addr !== ea[i] || obs_q[i].data !== ed[i] || obs_q[i].ok !== 1'b1 ||
                  obs_q[i].wrap !== 1'b0 || obs_q[i].cyc != wcyc[i])
            $display("[TB] FAIL b2b_write%0d: got %h @%h wrap=%b cyc=%0d want %h @%h wrap=0 cyc=%0d",
                     i, obs_q[i].data, obs_q[i].addr, obs_q[i].wrap, obs_q[i].cyc, ed[i], ea[i], wcyc[i]);
         else n_pass++;
      end
      n_checks++;
      if (word_cnt !== 9'd2 || busy !== 1'b1 || obs_q.size() != 2)
         $display("[TB] FAIL b2b_status: got cnt=%0d busy=%b writes=%0d want cnt=2 busy=1 writes=2",
                  word_cnt, busy, obs_q.size());
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic [7:0]  ea [2] = '{8'hFF, 8'h00};
      logic [15:0] ed [2] = '{16'hA2A1, 16'hA4A3};
      logic        ew [2] = '{1'b0, 1'b1};
      begin_session(8'hFF);
      obs_q.delete();
      send(8'hA1);
      send(8'hA2);
      send(8'hA3);
      send(8'hA4);
      idle(2);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (i >= obs_q.size())
            $display("[TB] FAIL wrap_write%0d: got none want %h @%h", i, ed[i], ea[i]);
         else if (obs_q[i].addr !== ea[i] || obs_q[i].data !== ed[i] || obs_q[i].ok !== 1'b1 ||
                  obs_q[i].wrap !== ew[i])
            $display("[TB] FAIL wrap_write%0d: got %h @%h wrap=%b want %h @%h wrap=%b",
                     i, obs_q[i].data, obs_q[i].addr, obs_q[i].wrap, ed[i], ea[i], ew[i]);
         else n_pass++;
      end
      n_checks++;
      if (obs_q.size() != 2) $display("[TB] FAIL wrap_count: got %0d want 2", obs_q.size());
      else n_pass++;
   endtask

   task automatic test_flush();
      logic [7:0]  ea [3] = '{8'h20, 8'h21, 8'h22};
      logic [15:0] ed [3] = '{16'h00AB, 16'hC35A, 16'hCDEF};
      logic        r0, r1;
      begin_session(8'h20);
      obs_q.delete();
      send(8'hAB);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
      idle(1);
      r0 = last_rdy;
      idle(1);
      r1 = last_rdy;
      n_checks++;
      if (r0 !== 1'b0 || r1 !== 1'b1)
         $display("[TB] FAIL flush_ready: got %b%b want 01", r0, r1);
      else n_pass++;
      send(8'h5A);
      send(8'hC3);
      idle(1);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
      idle(1);
      r0 = last_rdy;
      idle(2);
      r1 = last_rdy;
      n_checks++;
      if (r0 !== 1'b0 || r1 !== 1'b1 || obs_q.size() != 2)
         $display("[TB] FAIL flush_empty: got ready=%b%b writes=%0d want ready=01 writes=2",
                  r0, r1, obs_q.size());
      else n_pass++;
      send(8'hEF);
      step(1'b1, 8'hCD, 1'b1, 1'b0, 1'b0, 8'h00);
      idle(3);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (i >= obs_q.size())
            $display("[TB] FAIL flush_write%0d: got none want %h @%h", i, ed[i], ea[i]);
         else if (obs_q[i].addr !== ea[i] || obs_q[i].data !== ed[i] || obs_q[i].ok !== 1'b1)
            $display("[TB] FAIL flush_write%0d: got %h @%h want %h @%h",
                     i, obs_q[i].data, obs_q[i].addr, ed[i], ea[i]);
         else n_pass++;
      end
      n_checks++;
      if (obs_q.size() != 3) $display("[TB] FAIL flush_count: got %0d want 3", obs_q.size());
      else n_pass++;
   endtask

   task automatic test_stop();
      logic [7:0]  ea [2] = '{8'h30, 8'h31};
      logic [15:0] ed [2] = '{16'h0201, 16'h0003};
      begin_session(8'h30);
      obs_q.delete();
      send(8'h01);
      send(8'h02);
      send(8'h03);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      idle(2);
      n_checks++;
      if (busy !== 1'b0) $display("[TB] FAIL stop_busy: got %b want 0", busy);
      else n_pass++;
      send(8'h77);
      n_checks++;
      if (last_rdy !== 1'b0) $display("[TB] FAIL stop_ready: got %b want 0", last_rdy);
      else n_pass++;
      idle(2);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (i >= obs_q.size())
            $display("[TB] FAIL stop_write%0d: got none want %h @%h", i, ed[i], ea[i]);
         else if (obs_q[i].addr !== ea[i] || obs_q[i].data !== ed[i] || obs_q[i].ok !== 1'b1)
            $display("[TB] FAIL stop_write%0d: got %h @%h want %h @%h",
                     i, obs_q[i].data, obs_q[i].addr, ed[i], ea[i]);
         else n_pass++;
      end
      n_checks++;
      if (obs_q.size() != 2 || word_cnt !== 9'd2)
         $display("[TB] FAIL stop_status: got writes=%0d cnt=%0d want writes=2 cnt=2",
                  obs_q.size(), word_cnt);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      begin_session(8'h40);
      obs_q.delete();
      send(8'h99);
      do_reset();
      n_checks++;
      if ({enaA, weA, addrA, diA, word_cnt, wrap, busy, in_ready} !== 38'h0)
         $display("[TB] FAIL midreset_outputs: got %h want 0",
                  {enaA, weA, addrA, diA, word_cnt, wrap, busy, in_ready});
      else n_pass++;
      idle(2);
      n_checks++;
      if (obs_q.size() != 0) $display("[TB] FAIL midreset_nowrite: got %0d want 0", obs_q.size());
      else n_pass++;
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h80);
      send(8'h01);
      send(8'h02);
      idle(2);
      n_checks++;
      if (obs_q.size() != 1 || obs_q[0].addr !== 8'h80 || obs_q[0].data !== 16'h0201 ||
          word_cnt !== 9'd1)
         $display("[TB] FAIL midreset_resume: got writes=%0d cnt=%0d want 0201 @80 cnt=1",
                  obs_q.size(), word_cnt);
      else n_pass++;
   endtask

   task automatic test_random();
      int         accepted;
      logic       v;
      logic       fl;
      logic [7:0] d;
      int         n;
      begin_session(8'($urandom_range(0, 255)));
      obs_q.delete();
      exp_q.delete();
      foreach (mem_dut[i]) begin
         mem_dut[i] = '0;
         mem_ref[i] = '0;
      end
      accepted = 0;
      for (int s = 0; s < 5000 && accepted < 1024; s++) begin
         v  = ($urandom_range(0, 3) != 0);
         d  = 8'($urandom);
         fl = ($urandom_range(0, 63) == 0);
         if (v && m_mode == M_ACTIVE) accepted++;
         step(v, d, fl, 1'b0, 1'b0, 8'h00);
      end
      idle(2);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      idle(3);
      n_checks++;
      if (accepted != 1024 || obs_q.size() != exp_q.size())
         $display("[TB] FAIL rand_volume: got bytes=%0d writes=%0d want bytes=1024 writes=%0d",
                  accepted, obs_q.size(), exp_q.size());
      else n_pass++;
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data ||
             obs_q[i].wrap !== exp_q[i].wrap || obs_q[i].ok !== 1'b1 || obs_q[i].cyc != exp_q[i].cyc)
            $display("[TB] FAIL rand_write%0d: got %h @%h wrap=%b cyc=%0d want %h @%h wrap=%b cyc=%0d",
                     i, obs_q[i].data, obs_q[i].addr, obs_q[i].wrap, obs_q[i].cyc,
                     exp_q[i].data, exp_q[i].addr, exp_q[i].wrap, exp_q[i].cyc);
         else n_pass++;
      end
      n_checks++;
      if (word_cnt !== 9'(m_cnt)) $display("[TB] FAIL rand_word_cnt: got %0d want %0d", word_cnt, m_cnt);
      else n_pass++;
      foreach (obs_q[i]) if (obs_q[i].ok === 1'b1) mem_dut[obs_q[i].addr] = obs_q[i].data;
      foreach (exp_q[i]) mem_ref[exp_q[i].addr] = exp_q[i].data;
      // Read back through the narrow port view: byte k of word n sits at n*RATIO + k.
      for (int b = 0; b < SIZEA * RATIO; b++) begin
         n_checks++;
         if (mem_dut[b / RATIO][(b % RATIO)*8 +: 8] !== mem_ref[b / RATIO][(b % RATIO)*8 +: 8])
            $display("[TB] FAIL rand_ram_byte%0d: got %h want %h", b,
                     mem_dut[b / RATIO][(b % RATIO)*8 +: 8], mem_ref[b / RATIO][(b % RATIO)*8 +: 8]);
         else n_pass++;
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] simulation did not complete");
   end

   initial begin
      $display("[TB] starting asym_ram_wr_packer bench");
      test_reset();
      test_back_to_back();
      test_wrap();
      test_flush();
      test_stop();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
